// File: rtl/tick_sequencer_pkg.sv
// Shared definitions for the tick sequencer: FSM state encoding and tick counter width.
package tick_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_e;

    localparam int TICK_COUNT_W = 32;

endpackage

// File: rtl/tick_sequencer_divider.sv
// Programmable down-counter for the tick divider; expired flags the cycle on which a RUN tick is due.
module tick_sequencer_divider #(
    parameter int unsigned             NR_OF_BITS  = 16,
    parameter logic [NR_OF_BITS-1:0]   RESET_VALUE = '0
) (
    input  logic                  s_clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [NR_OF_BITS-1:0] load_value,
    input  logic                  dec,
    output logic                  expired
);

    logic [NR_OF_BITS-1:0] cnt_reg;

    // load wins over dec; with neither asserted the count holds
    always_ff @(posedge s_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= RESET_VALUE;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (dec) begin
            cnt_reg <= cnt_reg - NR_OF_BITS'(1);
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/tick_sequencer.sv
// Run/halt/single-step controller producing the registered core tick, with divider,
// breakpoint halt and a free-running count of issued ticks.
module tick_sequencer
    import tick_sequencer_pkg::*;
#(
    parameter int unsigned           NR_OF_BITS    = 16,
    parameter bit                    START_RUNNING = 1'b1,
    parameter logic [NR_OF_BITS-1:0] RESET_DIVISOR = '0
) (
    input  logic                    s_clock,
    input  logic                    reset_n,
    input  logic [NR_OF_BITS-1:0]   divisor,
    input  logic                    div_load,
    input  logic                    run_req,
    input  logic                    halt_req,
    input  logic                    step_req,
    input  logic                    break_match,
    input  logic                    count_clear,
    output logic                    tick,
    output logic                    running,
    output logic                    break_hit,
    output logic [TICK_COUNT_W-1:0] tick_count
);

    seq_state_e              state_reg, state_next;
    logic                    tick_reg, tick_next;
    logic                    break_hit_reg, break_hit_next;
    logic [NR_OF_BITS-1:0]   divisor_reg;
    logic [TICK_COUNT_W-1:0] tick_count_reg;
    logic                    reload, dec, expired;

    tick_sequencer_divider #(
        .NR_OF_BITS  (NR_OF_BITS),
        .RESET_VALUE (RESET_DIVISOR)
    ) u_divider (
        .s_clock    (s_clock),
        .reset_n    (reset_n),
        .load       (reload | div_load),
        .load_value (div_load ? divisor : divisor_reg),
        .dec        (dec),
        .expired    (expired)
    );

    // Request priority everywhere: halt > step > (break) > run
    always_comb begin
        state_next     = state_reg;
        tick_next      = 1'b0;
        break_hit_next = break_hit_reg;
        reload         = 1'b0;
        dec            = 1'b0;
        case (state_reg)
            ST_HALT: begin
                reload = 1'b1;
                if (!halt_req) begin
                    if (step_req) begin
                        state_next     = ST_STEP;
                        tick_next      = 1'b1;
                        break_hit_next = 1'b0;
                    end else if (run_req) begin
                        state_next     = ST_RUN;
                        break_hit_next = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                    reload     = 1'b1;
                end else if (step_req) begin
                    state_next = ST_STEP;
                    tick_next  = 1'b1;
                    reload     = 1'b1;
                end else if (tick_reg && break_match) begin
                    state_next     = ST_HALT;
                    break_hit_next = 1'b1;
                    reload         = 1'b1;
                end else if (expired) begin
                    tick_next = 1'b1;
                    reload    = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            ST_STEP: begin
                // the step tick is on the wire this cycle; always fall back to HALT
                state_next = ST_HALT;
                reload     = 1'b1;
                if (break_match) begin
                    break_hit_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_HALT;
                reload     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge s_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= START_RUNNING ? ST_RUN : ST_HALT;
            tick_reg       <= 1'b0;
            break_hit_reg  <= 1'b0;
            divisor_reg    <= RESET_DIVISOR;
            tick_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            break_hit_reg <= break_hit_next;
            if (div_load) begin
                divisor_reg <= divisor;
            end
            if (count_clear) begin
                tick_count_reg <= '0;
            end else if (tick_reg) begin
                tick_count_reg <= tick_count_reg + TICK_COUNT_W'(1);
            end
        end
    end

    assign tick       = tick_reg;
    assign running    = (state_reg == ST_RUN);
    assign break_hit  = break_hit_reg;
    assign tick_count = tick_count_reg;

endmodule
